// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the dmem arbiter: the sequencer state encoding and the
// requester port identifiers used for win_id / last_gnt.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic PORT_PROC = 1'b0;   // processor load/store path
    localparam logic PORT_DBG  = 1'b1;   // debug / loader path

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Purely combinational 2-way picker.
//   req0, req1   : request lines
//   last_gnt     : port granted most recently
//   valid        : at least one request present
//   win_id       : selected port (only meaningful while valid)
// FIX_PRIORITY = 0 alternates on a tie (the port that did not win last time);
// FIX_PRIORITY = 1 always hands a tie to port 0.
// -----------------------------------------------------------------------------
module rr_pick2
    import dmem_arbiter_pkg::*;
#(
    parameter bit FIX_PRIORITY = 1'b0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic valid,
    output logic win_id
);

    always_comb begin
        valid  = req0 | req1;
        win_id = PORT_PROC;
        if (req0 && req1) begin
            if (FIX_PRIORITY) win_id = PORT_PROC;
            else              win_id = ~last_gnt;
        end else if (req1) begin
            win_id = PORT_DBG;
        end
    end

endmodule : rr_pick2

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port dmem syncram between the processor port (0) and the
// debug/loader port (1). Accesses are serialised by a three-state sequencer,
// giving one access every three cycles.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | sample req0/req1; latch winner's address/data/we on the edge
//   ISSUE | gnt<win> high, dmem samples address/data/wren at closing edge
//   RESP  | mem_q valid; captured into rdata<win> for loads, rvalid next
//
// Ports
//   clock, reset          : clock shared with dmem, async active-high reset
//   req*/we*/addr*/wdata* : requester inputs, held stable until gnt*
//   gnt*, rvalid*, rdata* : registered grant / completion pulses, load data
//   mem_address/mem_data/mem_wren/mem_q : dmem interface
//   busy                  : sequencer not in IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int FIX_PRIORITY = 0
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,

    output logic              busy
);

    state_t state;
    state_t state_nxt;

    logic last_gnt;
    logic win_id;
    logic wren_q;

    logic pick_valid;
    logic pick_id;
    logic take;      // IDLE edge that accepts a new access
    logic finish;    // RESP edge that completes the current access

    rr_pick2 #(
        .FIX_PRIORITY (FIX_PRIORITY != 0)
    ) u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .valid    (pick_valid),
        .win_id   (pick_id)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    take      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = RESP;
            RESP: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and handshake registers. gnt/rvalid default low each cycle so
    // every pulse is exactly one cycle wide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_gnt    <= PORT_DBG;   // port 0 wins the first tie
            win_id      <= PORT_PROC;
            wren_q      <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;

            if (take) begin
                win_id   <= pick_id;
                last_gnt <= pick_id;
                if (pick_id == PORT_DBG) begin
                    mem_address <= addr1;
                    mem_data    <= wdata1;
                    wren_q      <= we1;
                    gnt1        <= 1'b1;
                end else begin
                    mem_address <= addr0;
                    mem_data    <= wdata0;
                    wren_q      <= we0;
                    gnt0        <= 1'b1;
                end
            end

            if (finish) begin
                if (win_id == PORT_DBG) begin
                    rvalid1 <= 1'b1;
                    if (!wren_q) rdata1 <= mem_q;
                end else begin
                    rvalid0 <= 1'b1;
                    if (!wren_q) rdata0 <= mem_q;
                end
            end
        end
    end

    // Decoded from the state register so a reset mid-ISSUE removes the write
    // strobe immediately rather than at the next edge.
    assign mem_wren = (state == ISSUE) && wren_q;
    assign busy     = (state != IDLE);

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. u_dut (round-robin) is attached to a small
// syncram model; u_fix (fixed priority) shares the data inputs but has its own
// request lines and is used only for the fixed-priority scenario.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [11:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic        busy;

    logic        req0_b, req1_b;
    logic        gnt0_b, rvalid0_b, gnt1_b, rvalid1_b;
    logic [31:0] rdata0_b, rdata1_b;
    logic [11:0] mem_address_b;
    logic [31:0] mem_data_b;
    logic        mem_wren_b;
    logic [31:0] mem_q_b;
    logic        busy_b;

    int vectors;
    int miscompares;
    int grant_log[$];

    logic [31:0] mem [0:4095];

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .FIX_PRIORITY(0)) u_dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .FIX_PRIORITY(1)) u_fix (
        .clock(clock), .reset(reset),
        .req0(req0_b), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
        .req1(req1_b), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
        .mem_address(mem_address_b), .mem_data(mem_data_b), .mem_wren(mem_wren_b),
        .mem_q(mem_q_b), .busy(busy_b)
    );

    assign mem_q_b = 32'h0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // syncram model: registered read, write on wren
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    task automatic drive(input logic p, input logic w, input logic [11:0] a, input logic [31:0] d);
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic drop(input logic p);
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    task automatic set_req(input bit use_b, input logic p, input logic v);
        if (use_b) begin if (p) req1_b = v; else req0_b = v; end
        else       begin if (p) req1   = v; else req0   = v; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // One access on u_dut, starting at a negedge in IDLE. Returns the number of
    // negedges until gnt and until rvalid; ends on the rvalid negedge.
    task automatic access(input logic p, input logic w, input logic [11:0] a,
                          input logic [31:0] d, output bit tmo, output int glat,
                          output int rlat);
        int  n;
        bit  seen;
        tmo = 1'b0; glat = -1; rlat = -1; n = 0; seen = 1'b0;
        drive(p, w, a, d);
        while (!seen && n < 10) begin
            @(negedge clock); n++;
            if ((p ? gnt1 : gnt0) === 1'b1) seen = 1'b1;
        end
        glat = n;
        drop(p);
        if (!seen) begin tmo = 1'b1; return; end
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clock); n++;
            if ((p ? rvalid1 : rvalid0) === 1'b1) seen = 1'b1;
        end
        rlat = n;
        if (!seen) tmo = 1'b1;
    endtask

    // Both ports keep requesting: each drops req on its gnt and re-asserts the
    // following cycle with its next store. Grant order goes to grant_log.
    task automatic run_tie(input bit use_b, input int n0, input int n1, output bit both_hi);
        int   c0, c1, cyc;
        bit   pend0, pend1;
        logic g0, g1;
        grant_log.delete();
        both_hi = 1'b0; c0 = 0; c1 = 0; pend0 = 1'b0; pend1 = 1'b0; cyc = 0;
        we0 = 1'b1; addr0 = 12'h100; wdata0 = 32'hA0A0_A0A0;
        we1 = 1'b1; addr1 = 12'h020; wdata1 = 32'h1111_1111;
        set_req(use_b, 1'b0, n0 > 0);
        set_req(use_b, 1'b1, n1 > 0);
        while (grant_log.size() < n0 + n1 && cyc < 60) begin
            @(negedge clock); cyc++;
            g0 = use_b ? gnt0_b : gnt0;
            g1 = use_b ? gnt1_b : gnt1;
            if (g0 === 1'b1 && g1 === 1'b1) both_hi = 1'b1;
            if (pend0) begin
                addr0 = 12'h100 + 12'(c0); wdata0 = 32'hA0A0_A0A0 + 32'(c0);
                set_req(use_b, 1'b0, 1'b1); pend0 = 1'b0;
            end
            if (pend1) begin
                addr1 = 12'h020 + 12'(c1); wdata1 = 32'h1111_1111 * 32'(c1 + 1);
                set_req(use_b, 1'b1, 1'b1); pend1 = 1'b0;
            end
            if (g0 === 1'b1) begin
                grant_log.push_back(0); c0++; set_req(use_b, 1'b0, 1'b0); pend0 = (c0 < n0);
            end
            if (g1 === 1'b1) begin
                grant_log.push_back(1); c1++; set_req(use_b, 1'b1, 1'b0); pend1 = (c1 < n1);
            end
        end
        set_req(use_b, 1'b0, 1'b0);
        set_req(use_b, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h055; wdata0 = 32'h1234_5678;
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 000000", {gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy});
        end
        vectors++;
        if (mem_address !== 12'h000) begin
            miscompares++; $display("FAIL reset_addr: got %h expected 000", mem_address);
        end
        vectors++;
        if (mem_data !== 32'h0) begin
            miscompares++; $display("FAIL reset_data: got %h expected 0", mem_data);
        end
        vectors++;
        if ({rdata0, rdata1} !== 64'h0) begin
            miscompares++; $display("FAIL reset_rdata: got %h/%h expected 0/0", rdata0, rdata1);
        end
        vectors++;
        if ({gnt0_b, gnt1_b, busy_b} !== 3'b0) begin
            miscompares++; $display("FAIL reset_fix: got %b expected 000", {gnt0_b, gnt1_b, busy_b});
        end
        req0 = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || gnt0 !== 1'b0) begin
            miscompares++; $display("FAIL reset_release: got busy=%b gnt0=%b expected 0 0", busy, gnt0);
        end
    endtask

    task automatic test_single_store_load();
        drive(1'b0, 1'b1, 12'h010, 32'hDEAD_BEEF);
        @(negedge clock);   // N+1 (ISSUE)
        vectors++;
        if ({gnt0, gnt1, mem_wren, busy} !== 4'b1011) begin
            miscompares++; $display("FAIL store_issue: got gnt0,gnt1,wren,busy=%b expected 1011", {gnt0, gnt1, mem_wren, busy});
        end
        vectors++;
        if (mem_address !== 12'h010 || mem_data !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL store_bus: got %h/%h expected 010/deadbeef", mem_address, mem_data);
        end
        drop(1'b0);
        @(negedge clock);   // N+2 (RESP)
        vectors++;
        if ({gnt0, mem_wren, rvalid0, busy} !== 4'b0001) begin
            miscompares++; $display("FAIL store_resp: got gnt0,wren,rvalid0,busy=%b expected 0001", {gnt0, mem_wren, rvalid0, busy});
        end
        @(negedge clock);   // N+3
        vectors++;
        if ({rvalid0, rvalid1, busy} !== 3'b100) begin
            miscompares++; $display("FAIL store_done: got rvalid0,rvalid1,busy=%b expected 100", {rvalid0, rvalid1, busy});
        end
        drive(1'b0, 1'b0, 12'h010, 32'h0);
        @(negedge clock);
        vectors++;
        if ({gnt0, mem_wren} !== 2'b10) begin
            miscompares++; $display("FAIL load_issue: got gnt0,wren=%b expected 10", {gnt0, mem_wren});
        end
        drop(1'b0);
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL load_data: got rvalid0=%b rdata0=%h expected 1 deadbeef", rvalid0, rdata0);
        end
        @(negedge clock);
        vectors++;
        if (rvalid0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL load_hold: got rvalid0=%b rdata0=%h expected 0 deadbeef", rvalid0, rdata0);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[4];
        bit both_hi, tmo;
        int glat, rlat;
        exp_order = '{0, 1, 0, 1};
        do_reset();
        run_tie(1'b0, 2, 2, both_hi);
        vectors++;
        if (grant_log.size() != 4) begin
            miscompares++; $display("FAIL rr_count: got %0d grants expected 4", grant_log.size());
        end
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            vectors++;
            if (grant_log[i] != exp_order[i]) begin
                miscompares++; $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, grant_log[i], exp_order[i]);
            end
        end
        vectors++;
        if (both_hi) begin
            miscompares++; $display("FAIL rr_exclusive: got gnt0 and gnt1 together expected never");
        end
        access(1'b1, 1'b0, 12'h020, 32'h0, tmo, glat, rlat);
        vectors++;
        if (tmo || rlat != 3 || rdata1 !== 32'h1111_1111) begin
            miscompares++; $display("FAIL rr_load20: got tmo=%0d lat=%0d rdata1=%h expected 0 3 11111111", tmo, rlat, rdata1);
        end
        access(1'b1, 1'b0, 12'h021, 32'h0, tmo, glat, rlat);
        vectors++;
        if (tmo || rdata1 !== 32'h2222_2222) begin
            miscompares++; $display("FAIL rr_load21: got tmo=%0d rdata1=%h expected 0 22222222", tmo, rdata1);
        end
        vectors++;
        if (rdata0 !== 32'h0) begin
            miscompares++; $display("FAIL rr_rdata0_hold: got %h expected 0", rdata0);
        end
    endtask

    task automatic test_late_request();
        drive(1'b0, 1'b1, 12'h040, 32'h4444_4444);
        @(negedge clock);   // ISSUE
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++; $display("FAIL late_gnt0: got %b expected 1", gnt0);
        end
        drop(1'b0);
        drive(1'b1, 1'b0, 12'h020, 32'h0);
        @(negedge clock);   // RESP
        vectors++;
        if ({busy, gnt1} !== 2'b10) begin
            miscompares++; $display("FAIL late_resp: got busy,gnt1=%b expected 10", {busy, gnt1});
        end
        @(negedge clock);   // IDLE
        vectors++;
        if ({rvalid0, gnt1, busy} !== 3'b100) begin
            miscompares++; $display("FAIL late_idle: got rvalid0,gnt1,busy=%b expected 100", {rvalid0, gnt1, busy});
        end
        @(negedge clock);
        vectors++;
        if ({gnt1, gnt0, busy} !== 3'b101) begin
            miscompares++; $display("FAIL late_gnt1: got gnt1,gnt0,busy=%b expected 101", {gnt1, gnt0, busy});
        end
        drop(1'b1);
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if (rvalid1 !== 1'b1 || rdata1 !== 32'h1111_1111) begin
            miscompares++; $display("FAIL late_data: got rvalid1=%b rdata1=%h expected 1 11111111", rvalid1, rdata1);
        end
    endtask

    task automatic test_fixed_priority();
        int exp_order[4];
        bit both_hi;
        exp_order = '{0, 0, 0, 1};
        do_reset();
        run_tie(1'b1, 3, 1, both_hi);
        vectors++;
        if (grant_log.size() != 4) begin
            miscompares++; $display("FAIL fp_count: got %0d grants expected 4", grant_log.size());
        end
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            vectors++;
            if (grant_log[i] != exp_order[i]) begin
                miscompares++; $display("FAIL fp_order[%0d]: got port %0d expected port %0d", i, grant_log[i], exp_order[i]);
            end
        end
        vectors++;
        if (both_hi || busy_b !== 1'b0) begin
            miscompares++; $display("FAIL fp_end: got both=%0d busy_b=%b expected 0 0", both_hi, busy_b);
        end
    endtask

    task automatic test_reset_mid_access();
        bit tmo, rv_seen;
        int glat, rlat;
        access(1'b0, 1'b1, 12'h030, 32'h3333_3333, tmo, glat, rlat);
        vectors++;
        if (tmo || glat != 1 || rlat != 3) begin
            miscompares++; $display("FAIL mid_pre: got tmo=%0d glat=%0d rlat=%0d expected 0 1 3", tmo, glat, rlat);
        end
        drive(1'b0, 1'b1, 12'h030, 32'hCAFE_F00D);
        @(negedge clock);   // ISSUE
        vectors++;
        if (mem_wren !== 1'b1) begin
            miscompares++; $display("FAIL mid_wren_on: got %b expected 1", mem_wren);
        end
        reset = 1'b1;
        drop(1'b0);
        #1;
        vectors++;
        if ({mem_wren, busy, gnt0} !== 3'b000) begin
            miscompares++; $display("FAIL mid_async: got wren,busy,gnt0=%b expected 000", {mem_wren, busy, gnt0});
        end
        @(negedge clock);
        reset = 1'b0;
        rv_seen = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) rv_seen = 1'b1;
        end
        vectors++;
        if (rv_seen) begin
            miscompares++; $display("FAIL mid_no_rvalid: got an rvalid pulse expected none");
        end
        vectors++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy} !== 6'b0 || mem_address !== 12'h0 ||
            mem_data !== 32'h0 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_outputs: got ctrl=%b addr=%h data=%h rd0=%h rd1=%h expected all 0",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_wren, busy}, mem_address, mem_data, rdata0, rdata1);
        end
        access(1'b0, 1'b0, 12'h030, 32'h0, tmo, glat, rlat);
        vectors++;
        if (tmo || rdata0 !== 32'h3333_3333) begin
            miscompares++; $display("FAIL mid_aborted_store: got tmo=%0d rdata0=%h expected 0 33333333", tmo, rdata0);
        end
    endtask

    task automatic test_boundary_address();
        bit tmo;
        int glat, rlat;
        access(1'b0, 1'b1, 12'h000, 32'h5A5A_5A5A, tmo, glat, rlat);
        access(1'b0, 1'b1, 12'hFFF, 32'h8000_0001, tmo, glat, rlat);
        vectors++;
        if (tmo || mem_address !== 12'hFFF) begin
            miscompares++; $display("FAIL bnd_store: got tmo=%0d addr=%h expected 0 fff", tmo, mem_address);
        end
        access(1'b0, 1'b0, 12'hFFF, 32'h0, tmo, glat, rlat);
        vectors++;
        if (tmo || rlat != 3 || rdata0 !== 32'h8000_0001) begin
            miscompares++; $display("FAIL bnd_load_fff: got tmo=%0d lat=%0d rdata0=%h expected 0 3 80000001", tmo, rlat, rdata0);
        end
        access(1'b0, 1'b0, 12'h000, 32'h0, tmo, glat, rlat);
        vectors++;
        if (tmo || rdata0 !== 32'h5A5A_5A5A) begin
            miscompares++; $display("FAIL bnd_no_wrap: got tmo=%0d rdata0=%h expected 0 5a5a5a5a", tmo, rdata0);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        req0_b = 1'b0; req1_b = 1'b0;

        test_reset();
        test_single_store_load();
        test_round_robin();
        test_late_request();
        test_fixed_priority();
        test_reset_mid_access();
        test_boundary_address();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dmem_arbiter
